// File: rtl/alu_sched_if.sv
// ============================================================================
// alu_sched_if : requester A/B and response bus for alu_sched (rev 1.0)
// Optional rsp_zero member present only when ALU_SCHED_ZFLAG_EN is defined.
// ============================================================================
`default_nettype none

interface alu_sched_if;
  logic        a_valid;
  logic [1:0]  a_op;
  logic [15:0] a_i0;
  logic [15:0] a_i1;
  logic        a_ready;

  logic        b_valid;
  logic [1:0]  b_op;
  logic [15:0] b_i0;
  logic [15:0] b_i1;
  logic        b_ready;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_o;
  logic        rsp_cout;
  logic        rsp_id;
`ifdef ALU_SCHED_ZFLAG_EN
  logic        rsp_zero;
`endif

  modport master (
    output a_valid, a_op, a_i0, a_i1,
    input  a_ready,
    output b_valid, b_op, b_i0, b_i1,
    input  b_ready,
    output rsp_ready,
    input  rsp_valid, rsp_o, rsp_cout, rsp_id
`ifdef ALU_SCHED_ZFLAG_EN
    , input rsp_zero
`endif
  );

  modport slave (
    input  a_valid, a_op, a_i0, a_i1,
    output a_ready,
    input  b_valid, b_op, b_i0, b_i1,
    output b_ready,
    input  rsp_ready,
    output rsp_valid, rsp_o, rsp_cout, rsp_id
`ifdef ALU_SCHED_ZFLAG_EN
    , output rsp_zero
`endif
  );
endinterface

`default_nettype wire

// File: rtl/alu_sched.sv
// ============================================================================
// alu_sched : two-requester round-robin scheduler around one shared 16-bit alu
// Optional macro ALU_SCHED_ZFLAG_EN adds rsp_zero.            rev 1.0
// ============================================================================
`default_nettype none

module alu (
  input  logic [1:0]  i_op,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_y,
  output logic        o_cout
);
  logic [16:0] w_sum;

  always_comb begin
    w_sum  = 17'd0;
    o_y    = 16'd0;
    o_cout = 1'b0;
    case (i_op)
      2'b00: begin
        w_sum  = {1'b0, i_a} + {1'b0, i_b};
        o_y    = w_sum[15:0];
        o_cout = w_sum[16];
      end
      2'b01: begin
        // carry out of a + ~b + 1 is the "no borrow" flag: set iff a >= b
        w_sum  = {1'b0, i_a} + {1'b0, ~i_b} + 17'd1;
        o_y    = w_sum[15:0];
        o_cout = w_sum[16];
      end
      2'b10:   o_y = i_a & i_b;
      default: o_y = i_a | i_b;
    endcase
  end
endmodule

module alu_sched (
  input  logic       clk,
  input  logic       reset,
  alu_sched_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_last_b;
  logic [1:0]  r_op;
  logic [15:0] r_i0;
  logic [15:0] r_i1;
  logic        r_id;
  logic        r_rsp_valid;
  logic [15:0] r_rsp_o;
  logic        r_rsp_cout;
  logic        r_rsp_id;
  logic        w_grant_b;
  logic        w_a_ready;
  logic        w_b_ready;
  logic [15:0] w_alu_y;
  logic        w_alu_cout;

  // B wins only when it is alone or when A was granted last
  assign w_grant_b = bus.b_valid & (~bus.a_valid | ~r_last_b);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_a_ready = 1'b0;
    w_b_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_a_ready = bus.a_valid & ~w_grant_b;
        w_b_ready = bus.b_valid & w_grant_b;
        if (w_a_ready | w_b_ready) w_next = S_EXEC;
      end
      S_EXEC:  w_next = S_RESP;
      S_RESP:  if (bus.rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  alu u_alu (
    .i_op   (r_op),
    .i_a    (r_i0),
    .i_b    (r_i1),
    .o_y    (w_alu_y),
    .o_cout (w_alu_cout)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_last_b    <= 1'b1;
      r_op        <= 2'd0;
      r_i0        <= 16'd0;
      r_i1        <= 16'd0;
      r_id        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_o     <= 16'd0;
      r_rsp_cout  <= 1'b0;
      r_rsp_id    <= 1'b0;
    end else begin
      if (w_a_ready | w_b_ready) begin
        r_op     <= w_b_ready ? bus.b_op : bus.a_op;
        r_i0     <= w_b_ready ? bus.b_i0 : bus.a_i0;
        r_i1     <= w_b_ready ? bus.b_i1 : bus.a_i1;
        r_id     <= w_b_ready;
        r_last_b <= w_b_ready;
      end
      if (r_state == S_EXEC) begin
        r_rsp_o     <= w_alu_y;
        r_rsp_cout  <= w_alu_cout;
        r_rsp_id    <= r_id;
        r_rsp_valid <= 1'b1;
      end else if ((r_state == S_RESP) && bus.rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_SCHED_ZFLAG_EN
  logic r_rsp_zero;

  always_ff @(posedge clk) begin
    if (!reset)                  r_rsp_zero <= 1'b0;
    else if (r_state == S_EXEC)  r_rsp_zero <= (w_alu_y == 16'd0);
  end

  assign bus.rsp_zero = r_rsp_zero;
`endif

  // readies are forced low while reset is asserted, even mid-cycle
  assign bus.a_ready   = w_a_ready & reset;
  assign bus.b_ready   = w_b_ready & reset;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_o     = r_rsp_o;
  assign bus.rsp_cout  = r_rsp_cout;
  assign bus.rsp_id    = r_rsp_id;
endmodule

`default_nettype wire

// File: tb/tb_alu_sched.sv
// ============================================================================
// tb_alu_sched : directed vectors with a queue scoreboard and response monitor
// ============================================================================
`default_nettype none

module tb_alu_sched;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  alu_sched_if bus();

  alu_sched dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [15:0] o;
    logic        cout;
    logic        id;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_rsp(input logic id, input logic [15:0] o, input logic cout);
    exp_t e;
    e.o    = o;
    e.cout = cout;
    e.id   = id;
    sb.push_back(e);
  endtask

  // Response monitor: pops one expectation per completed handshake
  always @(negedge clk) begin
    exp_t e;
    if (bus.a_ready || bus.b_ready)
      chk("one_ready", {31'd0, bus.a_ready & bus.b_ready}, 32'd0);
    if (reset && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got o=%h id=%0d expected no response", bus.rsp_o, bus.rsp_id);
      end else begin
        e = sb.pop_front();
        chk("rsp_o",    {16'd0, bus.rsp_o},    {16'd0, e.o});
        chk("rsp_cout", {31'd0, bus.rsp_cout}, {31'd0, e.cout});
        chk("rsp_id",   {31'd0, bus.rsp_id},   {31'd0, e.id});
`ifdef ALU_SCHED_ZFLAG_EN
        chk("rsp_zero", {31'd0, bus.rsp_zero}, {31'd0, (e.o == 16'd0)});
`endif
      end
    end
  end

  // Drive one request and hold it until its ready is seen; returns 1 ns after the transfer edge
  task automatic send(input logic id, input logic [1:0] op, input logic [15:0] x, input logic [15:0] y);
    int n;
    if (!id) begin
      bus.a_valid = 1'b1; bus.a_op = op; bus.a_i0 = x; bus.a_i1 = y;
    end else begin
      bus.b_valid = 1'b1; bus.b_op = op; bus.b_i0 = x; bus.b_i1 = y;
    end
    n = 0;
    forever begin
      @(negedge clk);
      if (id ? bus.b_ready : bus.a_ready) break;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout: requester %0d got no ready, expected within 50 cycles", id);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!id) bus.a_valid = 1'b0;
    else     bus.b_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.rsp_valid) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] snap_o;
    logic        snap_cout;
    logic        snap_id;
    int          n;

    bus.a_valid = 1'b0; bus.a_op = 2'd0; bus.a_i0 = 16'd0; bus.a_i1 = 16'd0;
    bus.b_valid = 1'b0; bus.b_op = 2'd0; bus.b_i0 = 16'd0; bus.b_i1 = 16'd0;
    bus.rsp_ready = 1'b1;
    reset = 1'b0;

    // Pending requests during reset must not see ready
    bus.a_valid = 1'b1; bus.a_i0 = 16'd1; bus.a_i1 = 16'd1;
    bus.b_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_o",     {16'd0, bus.rsp_o},     32'd0);
    chk("rst_rsp_cout",  {31'd0, bus.rsp_cout},  32'd0);
    chk("rst_rsp_id",    {31'd0, bus.rsp_id},    32'd0);
    chk("rst_a_ready",   {31'd0, bus.a_ready},   32'd0);
    chk("rst_b_ready",   {31'd0, bus.b_ready},   32'd0);
`ifdef ALU_SCHED_ZFLAG_EN
    chk("rst_rsp_zero",  {31'd0, bus.rsp_zero},  32'd0);
`endif
    @(posedge clk);
    #1;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    reset = 1'b1;

    // Tie right after reset: A first, then B
    expect_rsp(1'b0, 16'h3333, 1'b0);
    expect_rsp(1'b1, 16'h000F, 1'b1);
    fork
      send(1'b0, 2'b00, 16'h1111, 16'h2222);
      send(1'b1, 2'b01, 16'h0010, 16'h0001);
    join
    drain();

    // A add with latency check
    expect_rsp(1'b0, 16'h0007, 1'b0);
    send(1'b0, 2'b00, 16'h0003, 16'h0004);
    @(negedge clk);
    chk("lat_n1_valid", {31'd0, bus.rsp_valid}, 32'd0);
    @(negedge clk);
    chk("lat_n2_valid", {31'd0, bus.rsp_valid}, 32'd1);
    drain();

    expect_rsp(1'b1, 16'hFFFE, 1'b0);
    send(1'b1, 2'b01, 16'h0005, 16'h0007);
    drain();
    expect_rsp(1'b1, 16'h0002, 1'b1);
    send(1'b1, 2'b01, 16'h0007, 16'h0005);
    drain();
    expect_rsp(1'b0, 16'h0000, 1'b1);
    send(1'b0, 2'b00, 16'hFFFF, 16'h0001);
    drain();
    expect_rsp(1'b0, 16'hF000, 1'b0);
    send(1'b0, 2'b10, 16'hF0F0, 16'hFF00);
    drain();
    expect_rsp(1'b0, 16'hFFF0, 1'b0);
    send(1'b0, 2'b11, 16'hF0F0, 16'hFF00);
    drain();

    // Last grant was A, so a tie now goes to B first
    expect_rsp(1'b1, 16'h000F, 1'b0);
    expect_rsp(1'b0, 16'h1001, 1'b0);
    fork
      send(1'b1, 2'b10, 16'h00FF, 16'h0F0F);
      send(1'b0, 2'b11, 16'h1000, 16'h0001);
    join
    drain();

    // Back-pressure: response held for 5 cycles while B waits
    bus.rsp_ready = 1'b0;
    expect_rsp(1'b0, 16'h0300, 1'b0);
    expect_rsp(1'b1, 16'h0AB0, 1'b0);
    send(1'b0, 2'b00, 16'h0100, 16'h0200);
    bus.b_valid = 1'b1; bus.b_op = 2'b11; bus.b_i0 = 16'h0A00; bus.b_i1 = 16'h00B0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rsp_valid && n < 10);
    chk("stall_valid", {31'd0, bus.rsp_valid}, 32'd1);
    snap_o = bus.rsp_o; snap_cout = bus.rsp_cout; snap_id = bus.rsp_id;
    chk("stall_o_value", {16'd0, snap_o}, 32'h0300);
    repeat (5) begin
      @(negedge clk);
      chk("stall_hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("stall_hold_o",     {16'd0, bus.rsp_o},     {16'd0, snap_o});
      chk("stall_hold_cout",  {31'd0, bus.rsp_cout},  {31'd0, snap_cout});
      chk("stall_hold_id",    {31'd0, bus.rsp_id},    {31'd0, snap_id});
      chk("stall_a_ready",    {31'd0, bus.a_ready},   32'd0);
      chk("stall_b_ready",    {31'd0, bus.b_ready},   32'd0);
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("release_valid_drop", {31'd0, bus.rsp_valid}, 32'd0);
    chk("release_b_ready",    {31'd0, bus.b_ready},   32'd1);
    @(posedge clk);
    #1;
    bus.b_valid = 1'b0;
    drain();

    // Reset during EXEC discards the op; A then wins the next tie
    send(1'b0, 2'b00, 16'h0001, 16'h0001);
    reset = 1'b0;
    @(negedge clk);
    chk("exec_rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("exec_rst_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    @(posedge clk);
    #1;
    expect_rsp(1'b0, 16'h0000, 1'b1);
    expect_rsp(1'b1, 16'h8001, 1'b0);
    fork
      send(1'b0, 2'b01, 16'h0003, 16'h0003);
      send(1'b1, 2'b11, 16'h8000, 16'h0001);
    join
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

`default_nettype wire
